// File: rtl/booth_arbiter.sv
// booth_arbiter: shares one sequential booth multiplier among NREQ requesters.
// Define BOOTH_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).

module booth_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 4,
    parameter int LATENCY = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   op_x,
    input  logic [NREQ*W-1:0]   op_y,
    output logic [NREQ-1:0]     ack,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [2*W-1:0]      rsp_data,
    output logic                busy,
    output logic                mul_start,
    output logic [W-1:0]        mul_x,
    output logic [W-1:0]        mul_y,
    input  logic [2*W-1:0]      mul_result
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [2*W-1:0]    rsp_data_q, rsp_data_d;
    logic              busy_q, busy_d;
    logic              mul_start_q, mul_start_d;
    logic [W-1:0]      mul_x_q, mul_x_d;
    logic [W-1:0]      mul_y_q, mul_y_d;

    logic              found;
    logic [IW-1:0]     win;
    logic [IW-1:0]     idx;

`ifdef BOOTH_ARB_RR_EN
    logic [IW-1:0]     ptr_q, ptr_d;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction
`endif

    // Winner selection: first asserted request scanning upward from the search origin
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
`ifdef BOOTH_ARB_RR_EN
            idx = wrap_add(ptr_q, i);
`else
            idx = IW'(i);
`endif
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        ack_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        mul_start_d = 1'b0;
        mul_x_d     = mul_x_q;
        mul_y_d     = mul_y_q;
`ifdef BOOTH_ARB_RR_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d     = S_START;
                    grant_d     = win;
                    mul_x_d     = op_x[int'(win)*W +: W];
                    mul_y_d     = op_y[int'(win)*W +: W];
                    ack_d[win]  = 1'b1;
                    mul_start_d = 1'b1;
`ifdef BOOTH_ARB_RR_EN
                    ptr_d       = wrap_add(win, 1);
`endif
                end
            end
            S_START: begin
                state_d = S_WAIT;
                cnt_d   = CW'(LATENCY - 1);
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d              = S_DONE;
                    rsp_data_d           = mul_result;
                    rsp_valid_d[grant_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Outputs are registered alongside the state so every port changes only on a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            cnt_q       <= '0;
            ack_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            mul_start_q <= 1'b0;
            mul_x_q     <= '0;
            mul_y_q     <= '0;
`ifdef BOOTH_ARB_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            mul_start_q <= mul_start_d;
            mul_x_q     <= mul_x_d;
            mul_y_q     <= mul_y_d;
`ifdef BOOTH_ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign ack       = ack_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign mul_start = mul_start_q;
    assign mul_x     = mul_x_q;
    assign mul_y     = mul_y_q;

endmodule

// File: tb/tb_booth_arbiter.sv
// tb_booth_arbiter: directed scenarios plus randomized traffic against a transaction-age model.
// Build with or without BOOTH_ARB_RR_EN; the model follows the same macro.

module tb_booth_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int LAT  = 5;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b1;
    logic [NREQ-1:0]     req   = '0;
    logic [NREQ*W-1:0]   op_x  = '0;
    logic [NREQ*W-1:0]   op_y  = '0;
    logic [2*W-1:0]      mul_result = '0;
    logic [NREQ-1:0]     ack;
    logic [NREQ-1:0]     rsp_valid;
    logic [2*W-1:0]      rsp_data;
    logic                busy;
    logic                mul_start;
    logic [W-1:0]        mul_x;
    logic [W-1:0]        mul_y;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit                m_active = 1'b0;
    int                m_age    = 0;
    int                m_g      = 0;
    int                m_ptr    = 0;
    logic [NREQ-1:0]   e_ack       = '0;
    logic [NREQ-1:0]   e_rsp_valid = '0;
    logic [2*W-1:0]    e_rsp_data  = '0;
    logic              e_busy      = 1'b0;
    logic              e_start     = 1'b0;
    logic [W-1:0]      e_x         = '0;
    logic [W-1:0]      e_y         = '0;

    int                       mstart = -1000;
    logic signed [2*W-1:0]    mprod  = '0;

    booth_arbiter #(.NREQ(NREQ), .W(W), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .op_x       (op_x),
        .op_y       (op_y),
        .ack        (ack),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .mul_start  (mul_start),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_result (mul_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [2*W-1:0] prodOf(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = $signed(a) * $signed(b);
        return p;
    endfunction

    function automatic int pickWinner(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++)
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a transaction is just its age in cycles since the grant edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0; m_age = 0; m_g = 0; m_ptr = 0;
            e_ack = '0; e_rsp_valid = '0; e_rsp_data = '0;
            e_busy = 1'b0; e_start = 1'b0; e_x = '0; e_y = '0;
        end else begin
            int g;
            e_ack = '0; e_start = 1'b0; e_rsp_valid = '0;
            if (m_active) begin
                m_age++;
                if (m_age == LAT + 2) begin
                    e_rsp_data       = prodOf(e_x, e_y);
                    e_rsp_valid[m_g] = 1'b1;
                end
                if (m_age == LAT + 3) m_active = 1'b0;
            end else begin
                g = pickWinner(req, m_ptr);
                if (g >= 0) begin
                    m_active = 1'b1; m_age = 1; m_g = g;
                    e_x = op_x[g*W +: W];
                    e_y = op_y[g*W +: W];
                    e_ack[g] = 1'b1;
                    e_start  = 1'b1;
`ifdef BOOTH_ARB_RR_EN
                    m_ptr = (g + 1) % NREQ;
`endif
                end
            end
            e_busy = m_active;
        end
    end

    // Per-cycle compare, then a behavioural multiplier that is only correct on its sampling edge
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("ack",       ack,       e_ack);
            checkOutput("rsp_valid", rsp_valid, e_rsp_valid);
            checkOutput("rsp_data",  rsp_data,  e_rsp_data);
            checkOutput("busy",      busy,      e_busy);
            checkOutput("mul_start", mul_start, e_start);
            checkOutput("mul_x",     mul_x,     e_x);
            checkOutput("mul_y",     mul_y,     e_y);
        end
        if (!rst_n) mstart = -1000;
        else if (mul_start === 1'b1) begin
            mstart = cyc + 1;
            mprod  = $signed(mul_x) * $signed(mul_y);
        end
        if (cyc + 1 == mstart + LAT) mul_result = mprod;
        else mul_result = (2*W)'($urandom);
    end

    task automatic applyStimulus();
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && e_ack[i]) begin
                if ($urandom_range(0, 7) != 0) req[i] = 1'b0;
            end else if (req[i]) begin
                if ($urandom_range(0, 31) == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                req[i] = 1'b1;
                op_x[i*W +: W] = W'($urandom);
                op_y[i*W +: W] = W'($urandom);
            end
        end
    endtask

    task automatic idle(input int n);
        req = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic single(input int i, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [2*W-1:0] expProd, input string tag);
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[i] = 1'b1;
        @(negedge clk);
        req = '0;
        op_x[i*W +: W] = x;
        op_y[i*W +: W] = y;
        req[i] = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_ack"}, ack, oh);
        checkOutput({tag, "_start"}, mul_start, 1);
        req[i] = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        checkOutput({tag, "_rsp_valid"}, rsp_valid, oh);
        checkOutput({tag, "_rsp_data"}, rsp_data, expProd);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ack"},       ack,       0);
        checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
        checkOutput({tag, "_rsp_data"},  rsp_data,  0);
        checkOutput({tag, "_busy"},      busy,      0);
        checkOutput({tag, "_mul_start"}, mul_start, 0);
        checkOutput({tag, "_mul_x"},     mul_x,     0);
        checkOutput({tag, "_mul_y"},     mul_y,     0);
    endtask

    initial begin
        logic [NREQ-1:0] order [5];
        int  seen;
        int  cnt;
        bit  found;

        #1 rst_n = 1'b0;
        #1 checkAllZero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

`ifdef BOOTH_ARB_RR_EN
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        op_x = 16'h4321;
        op_y = 16'h1234;
        req  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            found = 1'b0;
            for (int c = 0; c < LAT + 6 && !found; c++) begin
                @(negedge clk);
                if (ack != '0) found = 1'b1;
            end
            checkOutput($sformatf("t3_ack%0d", k), found ? ack : 4'b0000, order[k]);
        end
        idle(LAT + 5);

        single(0, 4'b0011, 4'b0100, 8'h0C, "t1");
        idle(2);
        single(2, 4'b1110, 4'b0011, 8'hFA, "t2");
        idle(2);

        @(negedge clk);
        op_x[3:0] = 4'd7; op_y[3:0] = 4'd2; req[0] = 1'b1;
        @(negedge clk);
        checkOutput("t4_ack0", ack, 4'b0001);
        req[0] = 1'b0;
        repeat (2) @(negedge clk);
        op_x[7:4] = 4'd3; op_y[7:4] = 4'd3; req[1] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < LAT + 4 && !found; c++) begin
            @(negedge clk);
            if (ack[1]) seen = 1;
            if (rsp_valid[0]) found = 1'b1;
        end
        checkOutput("t4_rsp0_seen", found, 1);
        @(negedge clk);
        checkOutput("t4_gap_busy", busy, 0);
        checkOutput("t4_gap_ack", ack, 0);
        @(negedge clk);
        checkOutput("t4_ack1", ack, 4'b0010);
        req[1] = 1'b0;
        idle(LAT + 5);

        @(negedge clk);
        op_x[3:0] = 4'd6; op_y[3:0] = 4'd5; req[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkAllZero("t5_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (rsp_valid != '0) cnt++;
        end
        checkOutput("t5_no_rsp", cnt, 0);
        single(3, 4'b0101, 4'b1101, 8'hF1, "t5b");
        idle(2);

        @(negedge clk);
        op_x[3:0] = 4'd2; op_y[3:0] = 4'd6; req[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        cnt = 0;
        @(negedge clk);
        op_x[7:4] = 4'd1; op_y[7:4] = 4'd1; req[1] = 1'b1;
        @(negedge clk);
        req[1] = 1'b0;
        repeat (LAT + 6) begin
            if (ack[1] || rsp_valid[1]) cnt++;
            @(negedge clk);
        end
        checkOutput("t6_no_grant1", cnt, 0);
        idle(2);

        repeat (3000) begin
            @(negedge clk);
            applyStimulus();
        end
        idle(LAT + 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
